// File: rtl/fetch_pc_sequencer.sv
// Front-end fetch sequencer: owns the fetch PC, keeps one imem request in flight,
// and chooses the next PC as ROB redirect, then predicted target, then PC+4.
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        iq_full,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst,
  output logic [31:0] fetch_pc_next,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_STALL, S_DROP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] w_seq_pc;
  logic        r_hold_valid;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_inst;
  logic [31:0] r_hold_npc;
  logic        w_hold_load;
  logic        w_hold_clear;
  logic [15:0] r_flush_count;
  logic        w_flush_inc;

  // Successor of the instruction arriving this cycle, ignoring any redirect.
  assign w_seq_pc = pred_taken ? pred_target : (r_pc + 32'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ISSUE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_hold_load  = 1'b0;
    w_hold_clear = 1'b0;
    w_flush_inc  = 1'b0;
    case (r_state)
      S_ISSUE: begin
        w_state_next = S_WAIT;
        if (redirect_valid) begin
          w_pc_next    = redirect_pc;
          w_state_next = S_DROP;
        end
      end
      S_WAIT: begin
        if (imem_resp) begin
          w_state_next = S_ISSUE;
          if (redirect_valid) begin
            w_flush_inc = 1'b1;
            w_pc_next   = redirect_pc;
          end else if (!iq_full) begin
            w_pc_next = w_seq_pc;
          end else begin
            w_hold_load  = 1'b1;
            w_state_next = S_STALL;
          end
        end else if (redirect_valid) begin
          w_pc_next    = redirect_pc;
          w_state_next = S_DROP;
        end
      end
      S_STALL: begin
        if (redirect_valid) begin
          w_hold_clear = 1'b1;
          w_flush_inc  = 1'b1;
          w_pc_next    = redirect_pc;
          w_state_next = S_ISSUE;
        end else if (!iq_full) begin
          w_hold_clear = 1'b1;
          w_pc_next    = r_hold_npc;
          w_state_next = S_ISSUE;
        end
      end
      S_DROP: begin
        // A response for a squashed request is consumed; the latest redirect sets the PC.
        if (redirect_valid) begin
          w_pc_next = redirect_pc;
        end
        if (imem_resp) begin
          w_flush_inc  = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      default: begin
        w_state_next = S_ISSUE;
      end
    endcase
  end

  always_comb begin
    imem_rmask    = 4'h0;
    fetch_valid   = 1'b0;
    fetch_pc      = r_pc;
    fetch_inst    = imem_rdata;
    fetch_pc_next = r_pc;
    if (!rst) begin
      case (r_state)
        S_ISSUE: begin
          imem_rmask = 4'hF;
        end
        S_WAIT: begin
          if (imem_resp) begin
            fetch_pc_next = w_seq_pc;
            fetch_valid   = !redirect_valid && !iq_full;
          end
        end
        S_STALL: begin
          fetch_pc      = r_hold_pc;
          fetch_inst    = r_hold_inst;
          fetch_pc_next = r_hold_npc;
          fetch_valid   = r_hold_valid && !redirect_valid && !iq_full;
        end
        default: begin
          imem_rmask = 4'h0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_hold_valid  <= 1'b0;
      r_flush_count <= 16'd0;
    end else begin
      r_pc <= w_pc_next;
      if (w_hold_load) begin
        r_hold_valid <= 1'b1;
      end else if (w_hold_clear) begin
        r_hold_valid <= 1'b0;
      end
      if (w_flush_inc && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  // Hold payload needs no reset; it is only read while r_hold_valid is set.
  always_ff @(posedge clk) begin
    if (w_hold_load) begin
      r_hold_pc   <= r_pc;
      r_hold_inst <= imem_rdata;
      r_hold_npc  <= w_seq_pc;
    end
  end

  assign imem_addr   = r_pc;
  assign flush_count = r_flush_count;

endmodule
